md_issue_ctrl: RTL

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl_pkg.sv | 38 +++
 rtl/md_issue_ctrl_sign_fix.sv | 48 ++++
 rtl/md_issue_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared ALU control codes and helpers for the multiply/divide issue controller.
package md_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
  localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
  localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
  localparam logic [4:0] ALUCTRL_REM    = 5'h16;
  localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

  function automatic logic is_mop(input logic [4:0] ctrl);
    return ctrl[4:3] == 2'b10;
  endfunction

  function automatic logic is_divide(input logic [4:0] ctrl);
    return is_mop(ctrl) & ctrl[2];
  endfunction

  function automatic logic is_rem(input logic [4:0] ctrl);
    return (ctrl == ALUCTRL_REM) || (ctrl == ALUCTRL_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] ctrl);
    return (ctrl == ALUCTRL_DIV) || (ctrl == ALUCTRL_REM);
  endfunction

  // Architectural results for divide-by-zero and signed overflow.
  function automatic logic [XLEN-1:0] div_special(input logic rem, input logic div0,
                                                  input logic [XLEN-1:0] rs1);
    if (div0) return rem ? rs1 : '1;
    return rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  endfunction

endpackage

// File: rtl/md_issue_ctrl_sign_fix.sv
// md_sign_fix: operand magnitude conversion and result sign correction (combinational).
module md_sign_fix
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [4:0]          op_ctrl,
  input  logic [DATA_W-1:0]   op_rs1,
  input  logic [DATA_W-1:0]   op_rs2,
  output logic                op_sa,
  output logic                op_sb,
  output logic [DATA_W-1:0]   op_mag_a,
  output logic [DATA_W-1:0]   op_mag_b,
  input  logic [4:0]          res_ctrl,
  input  logic                res_sa,
  input  logic                res_sb,
  input  logic [2*DATA_W-1:0] res_raw,
  output logic [DATA_W-1:0]   res_data
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  always_comb begin
    op_sa    = op_rs1[DATA_W-1] &
               (op_ctrl inside {ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM});
    op_sb    = op_rs2[DATA_W-1] & (op_ctrl inside {ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM});
    op_mag_a = op_sa ? -op_rs1 : op_rs1;
    op_mag_b = op_sb ? -op_rs2 : op_rs2;
  end

  // Remainder takes the dividend's sign; quotient/product take the sign XOR.
  always_comb begin
    prod     = (res_sa ^ res_sb) ? -res_raw : res_raw;
    quo      = (res_sa ^ res_sb) ? -res_raw[DATA_W-1:0] : res_raw[DATA_W-1:0];
    rem      = res_sa ? -res_raw[2*DATA_W-1:DATA_W] : res_raw[2*DATA_W-1:DATA_W];
    res_data = '0;
    case (res_ctrl)
      ALUCTRL_MUL:                                  res_data = prod[DATA_W-1:0];
      ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:  res_data = prod[2*DATA_W-1:DATA_W];
      ALUCTRL_DIV, ALUCTRL_DIVU:                    res_data = quo;
      ALUCTRL_REM, ALUCTRL_REMU:                    res_data = rem;
      default:                                      res_data = '0;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/writeback controller for the multicycle mult/div unit.
// Optional MD_DIV_FASTPATH_EN: divide-by-zero and signed overflow complete without issuing.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_ctrl,
  input  logic [DATA_W-1:0] ex_rs1,
  input  logic [DATA_W-1:0] ex_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              md_valid,
  output logic              md_mode,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic              md_ready,
  input  logic [2*DATA_W-1:0] md_out,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN, ST_DONE} state_t;

  state_t            state, state_nx;
  logic [4:0]        ctrl_q, rd_q;
  logic              sa_q, sb_q, div0_q, ovf_q;
  logic              op_sa, op_sb;
  logic [DATA_W-1:0] op_mag_a, op_mag_b, res_data, rs1_rec;
  logic              ex_mop, ex_div0, ex_ovf, fast, accept, capture;

  assign ex_mop  = ex_valid & is_mop(ex_ctrl);
  assign ex_div0 = is_divide(ex_ctrl) & (ex_rs2 == '0);
  assign ex_ovf  = is_signed_div(ex_ctrl) & (ex_rs1 == {1'b1, {(DATA_W-1){1'b0}}}) &
                   (ex_rs2 == '1);
`ifdef MD_DIV_FASTPATH_EN
  assign fast = ex_div0 | ex_ovf;
`else
  assign fast = 1'b0;
`endif
  // Original rs1 is recovered from the held magnitude instead of storing a copy.
  assign rs1_rec = sa_q ? -md_a : md_a;

  md_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
    .op_ctrl  (ex_ctrl),
    .op_rs1   (ex_rs1),
    .op_rs2   (ex_rs2),
    .op_sa    (op_sa),
    .op_sb    (op_sb),
    .op_mag_a (op_mag_a),
    .op_mag_b (op_mag_b),
    .res_ctrl (ctrl_q),
    .res_sa   (sa_q),
    .res_sb   (sb_q),
    .res_raw  (md_out),
    .res_data (res_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    md_valid = 1'b0;
    wb_valid = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = ex_mop & ~flush;
        stall  = accept;
        if (accept) state_nx = fast ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        stall    = 1'b1;
        md_valid = 1'b1;
        state_nx = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (flush)         state_nx = ST_IDLE;
        else if (md_ready) begin
          capture  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DRAIN: begin
        stall = ex_mop;
        if (md_ready) state_nx = ST_IDLE;
      end
      ST_DONE: begin
        wb_valid = ~flush;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      rd_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      md_mode <= 1'b0;
      md_a    <= '0;
      md_b    <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        ctrl_q  <= ex_ctrl;
        rd_q    <= ex_rd;
        sa_q    <= op_sa;
        sb_q    <= op_sb;
        div0_q  <= ex_div0;
        ovf_q   <= ex_ovf;
        md_mode <= is_divide(ex_ctrl);
        md_a    <= op_mag_a;
        md_b    <= op_mag_b;
      end
      if (accept & fast) begin
        wb_rd   <= ex_rd;
        wb_data <= div_special(is_rem(ex_ctrl), ex_div0, ex_rs1);
      end
      if (capture) begin
        wb_rd   <= rd_q;
        wb_data <= (div0_q | ovf_q) ? div_special(is_rem(ctrl_q), div0_q, rs1_rec) : res_data;
      end
    end
  end

endmodule
